// File: rtl/studio_pkg.sv
// Shared types and memory map for the Studio II main-memory arbiter.
// The region bounds refer to addr[11:0]; the upper address bits only mirror them.
package studio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REQ_LOADER = 2'd0,
        REQ_DMA    = 2'd1,
        REQ_CPU    = 2'd2
    } req_e;

    localparam logic [11:0] BIOS_BASE     = 12'h000;
    localparam logic [11:0] CART_BASE     = 12'h400;
    localparam logic [11:0] ROM_SIZE      = 12'h400;
    localparam logic [11:0] RAM_BASE      = 12'h800;
    localparam logic [11:0] RAM_SIZE      = 12'h200;
    localparam logic [11:0] MAPPED_END    = RAM_BASE + RAM_SIZE;
    localparam logic [10:0] LOAD_LIMIT    = 11'h400;
    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

    function automatic logic is_mapped(input logic [11:0] addr);
        return addr < MAPPED_END;
    endfunction

    function automatic logic is_ram(input logic [11:0] addr);
        return (addr >= RAM_BASE) && (addr < MAPPED_END);
    endfunction

endpackage

// File: rtl/studio_loader_capture.sv
// HPS download capture: one-byte holding register, written-byte counter and
// the sticky BIOS/cartridge loaded flags derived from the download edges.
module studio_loader_capture
    import studio_pkg::*;
#(
    parameter int MIN_BIOS = 512
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        done_i,
    output logic        req_o,
    output logic [11:0] addr_o,
    output logic [7:0]  data_o,
    output logic        we_o,
    output logic        ioctl_wait,
    output logic        bios_loaded,
    output logic        cart_loaded,
    output logic        load_overflow
);
    localparam logic [10:0] MIN_BIOS_CNT = 11'(MIN_BIOS);

    logic        valid_q, valid_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic [10:0] cnt_q, cnt_d;
    logic        dl_q;
    logic        bios_q, bios_d;
    logic        cart_q, cart_d;
    logic        ovf_q, ovf_d;

    logic        idx_bios, idx_cart, idx_ok, in_range, accept, dl_rise, dl_fall;
    logic [11:0] new_addr;

    assign idx_bios = (ioctl_index == 8'd0);
    assign idx_cart = (ioctl_index == 8'd1);
    assign idx_ok   = idx_bios || idx_cart;
    assign in_range = (ioctl_addr < {13'd0, ROM_SIZE});
    assign accept   = ioctl_wr && idx_ok && !valid_q;
    assign new_addr = (idx_cart ? CART_BASE : BIOS_BASE) | {2'b00, ioctl_addr[9:0]};
    assign dl_rise  = ioctl_download && !dl_q;
    assign dl_fall  = !ioctl_download && dl_q;

    // A fresh byte is offered straight to the arbiter so it can win in the same cycle it arrives.
    assign req_o  = valid_q || accept;
    assign addr_o = valid_q ? addr_q : new_addr;
    assign data_o = valid_q ? data_q : ioctl_dout;
    assign we_o   = valid_q ? we_q : in_range;

    assign ioctl_wait    = valid_q;
    assign bios_loaded   = bios_q;
    assign cart_loaded   = cart_q;
    assign load_overflow = ovf_q;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        bios_d  = bios_q;
        cart_d  = cart_q;
        ovf_d   = ovf_q;
        if (done_i) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d = 1'b1;
            addr_d  = new_addr;
            data_d  = ioctl_dout;
            we_d    = in_range;
            if (in_range && (cnt_q != LOAD_LIMIT)) begin
                cnt_d = cnt_q + 11'd1;
            end
        end
        if (ioctl_wr && idx_ok && valid_q) begin
            ovf_d = 1'b1;
        end
        if (dl_rise && idx_ok) begin
            cnt_d = 11'd0;
            if (idx_bios) bios_d = 1'b0;
            if (idx_cart) cart_d = 1'b0;
        end
        if (dl_fall) begin
            if (idx_bios && (cnt_q >= MIN_BIOS_CNT)) bios_d = 1'b1;
            if (idx_cart && (cnt_q != 11'd0))        cart_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= 12'h000;
            data_q  <= 8'h00;
            we_q    <= 1'b0;
            cnt_q   <= 11'd0;
            dl_q    <= 1'b0;
            bios_q  <= 1'b0;
            cart_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            dl_q    <= ioctl_download;
            bios_q  <= bios_d;
            cart_q  <= cart_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/studio_mem_arbiter.sv
// Three-way arbiter (loader > DMA > CPU, with a CPU starvation guard) for the
// single-port 4 KB Studio II memory; every access takes IDLE -> MEM -> RESP.
module studio_mem_arbiter
    import studio_pkg::*;
#(
    parameter int DMA_MAX  = 8,
    parameter int MIN_BIOS = 512
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        bios_loaded,
    output logic        cart_loaded,
    output logic        load_overflow
);
    localparam int            SW           = $clog2(DMA_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(DMA_MAX);

    state_e        state_q, state_d;
    req_e          grant_q, grant_d;
    logic [11:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          unmapped_q, unmapped_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    dma_rdata_q, dma_rdata_d;
    logic [SW-1:0] starve_q, starve_d;

    logic        ld_req, ld_we, ld_done, cpu_starved;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data, resp_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{cpu_addr[15:12], dma_addr[15:12]};

    assign ld_done     = (state_q == ST_RESP) && (grant_q == REQ_LOADER);
    assign cpu_starved = cpu_req && (starve_q >= STARVE_LIMIT);
    assign resp_data   = unmapped_q ? UNMAPPED_DATA : mem_rdata;

    studio_loader_capture #(
        .MIN_BIOS(MIN_BIOS)
    ) u_loader (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .done_i        (ld_done),
        .req_o         (ld_req),
        .addr_o        (ld_addr),
        .data_o        (ld_data),
        .we_o          (ld_we),
        .ioctl_wait    (ioctl_wait),
        .bios_loaded   (bios_loaded),
        .cart_loaded   (cart_loaded),
        .load_overflow (load_overflow)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        unmapped_d  = unmapped_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        starve_d    = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_req) begin
                    grant_d     = REQ_LOADER;
                    mem_addr_d  = ld_addr;
                    mem_we_d    = ld_we;
                    mem_wdata_d = ld_data;
                    unmapped_d  = 1'b0;
                    state_d     = ST_MEM;
                end else if (dma_req && !cpu_starved) begin
                    grant_d    = REQ_DMA;
                    mem_addr_d = dma_addr[11:0];
                    unmapped_d = !is_mapped(dma_addr[11:0]);
                    starve_d   = cpu_req ? (starve_q + SW'(1)) : '0;
                    state_d    = ST_MEM;
                end else if (cpu_req) begin
                    grant_d     = REQ_CPU;
                    mem_addr_d  = cpu_addr[11:0];
                    // ROM and unmapped writes still run the full sequence, just without a strobe.
                    mem_we_d    = cpu_we && is_ram(cpu_addr[11:0]);
                    mem_wdata_d = cpu_wdata;
                    unmapped_d  = !is_mapped(cpu_addr[11:0]);
                    starve_d    = '0;
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (grant_q == REQ_DMA) begin
                    dma_rdata_d = resp_data;
                    dma_ack_d   = 1'b1;
                end else if (grant_q == REQ_CPU) begin
                    cpu_rdata_d = resp_data;
                    cpu_ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= REQ_LOADER;
            mem_addr_q  <= 12'h000;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            unmapped_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= UNMAPPED_DATA;
            dma_rdata_q <= UNMAPPED_DATA;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            unmapped_q  <= unmapped_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_studio_mem_arbiter.sv
// Directed bench for studio_mem_arbiter: CPU access vector table, download runs,
// starvation pattern, simultaneous-request ordering, overflow and mid-access reset.
module tb_studio_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        bios_loaded, cart_loaded, load_overflow;

    always #5 clk_sys = ~clk_sys;

    studio_mem_arbiter #(
        .DMA_MAX (8),
        .MIN_BIOS(512)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .dma_req       (dma_req),
        .dma_addr      (dma_addr),
        .dma_rdata     (dma_rdata),
        .dma_ack       (dma_ack),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .bios_loaded   (bios_loaded),
        .cart_loaded   (cart_loaded),
        .load_overflow (load_overflow)
    );

    // Memory macro stand-in with a backdoor port for preloading.
    logic [7:0]  mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = 12'h000;
    logic [7:0]  bd_data = 8'h00;

    always @(posedge clk_sys) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int          we_cnt = 0;
    logic [11:0] last_waddr = 12'h000;
    logic [7:0]  last_wdata = 8'h00;

    always @(negedge clk_sys) begin
        if (mem_we) begin
            we_cnt     = we_cnt + 1;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                              output int lat, output logic [7:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 20);
        rd = cpu_rdata;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic load_byte(input logic [24:0] a, input logic [7:0] d, output int lat, output logic w1);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        w1  = ioctl_wait;
        lat = 1;
        while (ioctl_wait && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [7:0] pat(input int i, input int r);
        return 8'(i) ^ 8'(r * 37 + 5);
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        exp_we;
    } cpu_vec_t;

    cpu_vec_t vecs [12];
    int       dl_len  [4] = '{600, 100, 512, 511};
    logic     dl_flag [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         lat, start, bad, bad_lat, nacks, cyc, nev;
        logic [7:0] rd;
        logic       w1, prev_wait;
        int         seq [18];
        int         order [3];

        vecs[0]  = '{1'b0, 16'h0805, 8'h00, 1'b1, 8'h5A, 1'b0};
        vecs[1]  = '{1'b1, 16'h0123, 8'hAA, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 16'h0810, 8'h3C, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 16'h0810, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[4]  = '{1'b0, 16'h0A40, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[5]  = '{1'b1, 16'h0A41, 8'h66, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 16'h1805, 8'h00, 1'b1, 8'h5A, 1'b0};
        vecs[7]  = '{1'b1, 16'h09FF, 8'hE1, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 16'hF9FF, 8'h00, 1'b1, 8'hE1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0400, 8'h00, 1'b1, 8'h99, 1'b0};
        vecs[10] = '{1'b1, 16'h0400, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 16'h0123, 8'h00, 1'b1, 8'h34, 1'b0};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = 8'h00; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h0; cpu_wdata = 8'h00; dma_req = 1'b0; dma_addr = 16'h0;
        repeat (3) tick();

        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_ioctl_wait", ioctl_wait, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'hFF);
        check("rst_dma_rdata", dma_rdata, 8'hFF);
        check("rst_flags", {bios_loaded, cart_loaded, load_overflow}, 0);
        reset = 1'b0;
        tick();

        poke(12'h805, 8'h5A);
        poke(12'hA40, 8'h12);
        poke(12'h400, 8'h99);
        poke(12'h123, 8'h34);
        poke(12'h830, 8'h4D);

        for (int v = 0; v < 12; v++) begin
            start = we_cnt;
            cpu_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd);
            $display("cpu vec %0d: we=%0b addr=%04h lat=%0d rdata=%02h writes=%0d",
                     v, vecs[v].we, vecs[v].addr, lat, rd, we_cnt - start);
            check($sformatf("vec%0d_latency", v), lat, 3);
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            check($sformatf("vec%0d_we_count", v), we_cnt - start, vecs[v].exp_we);
            if (vecs[v].exp_we) begin
                check($sformatf("vec%0d_waddr", v), last_waddr, vecs[v].addr[11:0]);
                check($sformatf("vec%0d_wdata", v), last_wdata, vecs[v].wdata);
            end
        end

        ioctl_index = 8'd0;
        for (int r = 0; r < 4; r++) begin
            ioctl_download = 1'b1;
            tick();
            tick();
            check($sformatf("bios%0d_cleared", r), bios_loaded, 0);
            start = we_cnt; bad_lat = 0;
            for (int i = 0; i < dl_len[r]; i++) begin
                load_byte(25'(i), pat(i, r), lat, w1);
                if (lat != 3 || !w1) bad_lat++;
            end
            ioctl_download = 1'b0;
            tick();
            tick();
            bad = 0;
            for (int i = 0; i < dl_len[r]; i++) if (mem[i] !== pat(i, r)) bad++;
            $display("bios run %0d: bytes=%0d writes=%0d bad_data=%0d bad_timing=%0d bios_loaded=%0b",
                     r, dl_len[r], we_cnt - start, bad, bad_lat, bios_loaded);
            check($sformatf("bios%0d_writes", r), we_cnt - start, dl_len[r]);
            check($sformatf("bios%0d_data", r), bad, 0);
            check($sformatf("bios%0d_timing", r), bad_lat, 0);
            check($sformatf("bios%0d_loaded", r), bios_loaded, dl_flag[r]);
        end

        ioctl_index = 8'd1; ioctl_download = 1'b1;
        tick();
        tick();
        check("cart_cleared", cart_loaded, 0);
        start = we_cnt;
        load_byte(25'h10, 8'hC3, lat, w1);
        $display("cart byte 0x10: lat=%0d waddr=%03h wdata=%02h", lat, last_waddr, last_wdata);
        check("cart_wait_rise", w1, 1);
        check("cart_latency", lat, 3);
        check("cart_we_count", we_cnt - start, 1);
        check("cart_waddr", last_waddr, 12'h410);
        check("cart_wdata", last_wdata, 8'hC3);
        start = we_cnt;
        load_byte(25'h400, 8'h5E, lat, w1);
        $display("cart byte 0x400: lat=%0d writes=%0d", lat, we_cnt - start);
        check("cart_oob_latency", lat, 3);
        check("cart_oob_no_write", we_cnt - start, 0);
        ioctl_download = 1'b0;
        tick();
        tick();
        check("cart_loaded", cart_loaded, 1);
        check("cart_bios_untouched", bios_loaded, 0);

        dma_req = 1'b1; dma_addr = 16'h0830; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0805;
        for (int k = 0; k < 18; k++) seq[k] = 0;
        nacks = 0; cyc = 0;
        while (nacks < 18 && cyc < 200) begin
            tick();
            cyc++;
            if (dma_ack && nacks < 18) begin seq[nacks] = 2; nacks++; end
            if (cpu_ack && nacks < 18) begin seq[nacks] = 3; nacks++; end
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        $display("starvation: %0d acks in %0d cycles, dma_rdata=%02h cpu_rdata=%02h",
                 nacks, cyc, dma_rdata, cpu_rdata);
        check("starve_ack_count", nacks, 18);
        for (int k = 0; k < 18; k++) check($sformatf("starve_seq%0d", k), seq[k], (k % 9 == 8) ? 3 : 2);
        check("starve_dma_rdata", dma_rdata, 8'h4D);
        check("starve_cpu_rdata", cpu_rdata, 8'h5A);
        tick();

        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h7E;
        dma_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        nev = 0; cyc = 0; prev_wait = ioctl_wait;
        order[0] = 0; order[1] = 0; order[2] = 0;
        while (nev < 3 && cyc < 40) begin
            tick();
            cyc++;
            ioctl_wr = 1'b0;
            if (prev_wait && !ioctl_wait && nev < 3) begin order[nev] = 1; nev++; end
            if (dma_ack && nev < 3) begin order[nev] = 2; nev++; dma_req = 1'b0; end
            if (cpu_ack && nev < 3) begin order[nev] = 3; nev++; cpu_req = 1'b0; end
            prev_wait = ioctl_wait;
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        $display("simultaneous: order=%0d,%0d,%0d after %0d cycles", order[0], order[1], order[2], cyc);
        check("order_events", nev, 3);
        check("order_first_loader", order[0], 1);
        check("order_second_dma", order[1], 2);
        check("order_third_cpu", order[2], 3);
        tick();

        check("ovf_before", load_overflow, 0);
        start = we_cnt;
        ioctl_wr = 1'b1; ioctl_addr = 25'h21; ioctl_dout = 8'h11;
        tick();
        check("ovf_wait_high", ioctl_wait, 1);
        ioctl_addr = 25'h22; ioctl_dout = 8'h22;
        tick();
        ioctl_wr = 1'b0;
        check("ovf_set", load_overflow, 1);
        cyc = 0;
        while (ioctl_wait && cyc < 20) begin tick(); cyc++; end
        $display("overflow: load_overflow=%0b writes=%0d last=%03h/%02h", load_overflow,
                 we_cnt - start, last_waddr, last_wdata);
        check("ovf_wait_fell", ioctl_wait, 0);
        check("ovf_one_write", we_cnt - start, 1);
        check("ovf_waddr", last_waddr, 12'h021);
        check("ovf_wdata", last_wdata, 8'h11);
        ioctl_download = 1'b0;
        tick();

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0820; cpu_wdata = 8'h55;
        tick();
        check("midrst_mem_we_in_mem", mem_we, 1);
        reset = 1'b1;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        $display("mid-access reset: mem_we=%0b mem_addr=%03h cpu_ack=%0b cpu_rdata=%02h",
                 mem_we, mem_addr, cpu_ack, cpu_rdata);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_cpu_ack", cpu_ack, 0);
        check("midrst_cpu_rdata", cpu_rdata, 8'hFF);
        check("midrst_dma_rdata", dma_rdata, 8'hFF);
        check("midrst_flags", {bios_loaded, cart_loaded, load_overflow, ioctl_wait}, 0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack || dma_ack || mem_we) bad++;
        end
        check("midrst_no_ack", bad, 0);
        cpu_access(1'b0, 16'h0805, 8'h00, lat, rd);
        $display("post-reset read 0805: lat=%0d rdata=%02h", lat, rd);
        check("postrst_latency", lat, 3);
        check("postrst_rdata", rd, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
